// File: rtl/keypad_pkg.sv
// Shared types and key decoding for the multi-tap keypad: scanner states,
// key roles and the index -> role / ASCII mapping.
package keypad_pkg;
    localparam int KEY_W = 8;

    typedef enum logic [1:0] {SCAN, DB_PRESS, HELD, DB_RELEASE} scan_state_e;
    typedef enum logic [2:0] {KEY_LETTER, KEY_COMMIT, KEY_CLEAR, KEY_SUBMIT_WORD, KEY_NONE} key_role_e;

    // Number of letters on key k that stay within 'A'..'Z'.
    function automatic int letter_count(input int k, input int lpk);
        int base;
        int avail;
        base  = 65 + k * lpk;
        avail = 90 - base + 1;
        if (avail <= 0) return 0;
        return (avail < lpk) ? avail : lpk;
    endfunction

    function automatic logic [7:0] letter_ascii(input int k, input int i, input int lpk);
        int code;
        code = 65 + k * lpk + i;
        return code[7:0];
    endfunction

    function automatic key_role_e key_role(input int idx, input int rows, input int cols, input int lpk);
        int n_letter;
        n_letter = (rows - 1) * cols;
        if (idx < n_letter) return (letter_count(idx, lpk) > 0) ? KEY_LETTER : KEY_NONE;
        if (idx == n_letter) return KEY_COMMIT;
        if (idx == n_letter + 1 && cols > 1) return KEY_CLEAR;
        if (idx == n_letter + 2 && cols > 2) return KEY_SUBMIT_WORD;
        return KEY_NONE;
    endfunction
endpackage

// File: rtl/keypad_scanner.sv
// Column scanner with press/release debounce; emits a one-cycle key event
// carrying the linear key index (row * COLS + col).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 3,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int SCAN_CYCLES     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROWS-1:0]  row_i,
    output logic [COLS-1:0]  col_o,
    output logic             key_event_o,
    output logic [KEY_W-1:0] key_index_o
);
    localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SCW = $clog2(SCAN_CYCLES + 1);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    scan_state_e      state_q, state_d;
    logic [ROWS-1:0]  row_meta_q, row_sync_q, row_cap_q, row_cap_d;
    logic [CIW-1:0]   col_idx_q, col_idx_d;
    logic [SCW-1:0]   dwell_q, dwell_d;
    logic [DBW-1:0]   db_q, db_d;
    logic             event_q, event_d;
    logic [KEY_W-1:0] index_q, index_d;
    logic [RIW-1:0]   row_low;

    assign col_o       = COLS'(1) << col_idx_q;
    assign key_event_o = event_q;
    assign key_index_o = index_q;

    // Lowest set row wins when several rows are active.
    always_comb begin
        row_low = '0;
        for (int r = ROWS - 1; r >= 0; r--)
            if (row_cap_q[r]) row_low = RIW'(r);
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        dwell_d   = dwell_q;
        db_d      = db_q;
        row_cap_d = row_cap_q;
        event_d   = 1'b0;
        index_d   = index_q;
        unique case (state_q)
            SCAN: begin
                if (dwell_q == SCW'(SCAN_CYCLES - 1)) begin
                    dwell_d = '0;
                    if (row_sync_q != '0) begin
                        state_d   = DB_PRESS;
                        row_cap_d = row_sync_q;
                        db_d      = '0;
                    end else begin
                        col_idx_d = (col_idx_q == CIW'(COLS - 1)) ? '0 : col_idx_q + 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            DB_PRESS: begin
                if (row_sync_q != row_cap_q) begin
                    state_d = SCAN;
                end else if (db_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = HELD;
                    event_d = 1'b1;
                    index_d = KEY_W'(int'(row_low) * COLS + int'(col_idx_q));
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            HELD: begin
                if (row_sync_q == '0) begin
                    state_d = DB_RELEASE;
                    db_d    = '0;
                end
            end
            DB_RELEASE: begin
                if (row_sync_q != '0)                        state_d = HELD;
                else if (db_q == DBW'(DEBOUNCE_CYCLES - 1))  state_d = SCAN;
                else                                         db_d = db_q + 1'b1;
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SCAN;
            row_meta_q <= '0;
            row_sync_q <= '0;
            row_cap_q  <= '0;
            col_idx_q  <= '0;
            dwell_q    <= '0;
            db_q       <= '0;
            event_q    <= 1'b0;
            index_q    <= '0;
        end else begin
            state_q    <= state_d;
            row_meta_q <= row_i;
            row_sync_q <= row_meta_q;
            row_cap_q  <= row_cap_d;
            col_idx_q  <= col_idx_d;
            dwell_q    <= dwell_d;
            db_q       <= db_d;
            event_q    <= event_d;
            index_q    <= index_d;
        end
    end
endmodule

// File: rtl/keypad_multitap.sv
// Multi-tap letter entry: cycles letters on repeated presses of one key,
// commits through a valid/ready handshake and flags dropped commits.
module keypad_multitap
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 3,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int SCAN_CYCLES     = 4,
    parameter int TAP_TIMEOUT     = 100,
    parameter int LETTERS_PER_KEY = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic            pending_valid,
    output logic [7:0]      pending_char,
    output logic            letter_valid,
    input  logic            letter_ready,
    output logic [7:0]      letter,
    output logic            word_submit,
    output logic            overflow
);
    localparam int TW = $clog2(TAP_TIMEOUT + 1);

    logic             key_event;
    logic [KEY_W-1:0] key_index;
    key_role_e        role;

    logic             pv_q, pv_d, lv_q, lv_d, sub_q, sub_d, ws_q, ws_d, ovf_q, ovf_d;
    logic [7:0]       pchar_q, pchar_d, letter_q, letter_d;
    logic [KEY_W-1:0] pkey_q, pkey_d, pidx_q, pidx_d;
    logic [TW-1:0]    tap_q, tap_d;
    logic             commit_req;
    int               nxt;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SCAN_CYCLES(SCAN_CYCLES)
    ) u_scanner (
        .clk(clk), .rst(rst), .row_i(row), .col_o(col),
        .key_event_o(key_event), .key_index_o(key_index)
    );

    assign role          = key_role(int'(key_index), ROWS, COLS, LETTERS_PER_KEY);
    assign pending_valid = pv_q;
    assign pending_char  = pchar_q;
    assign letter_valid  = lv_q;
    assign letter        = letter_q;
    assign word_submit   = ws_q;
    assign overflow      = ovf_q;

    always_comb begin
        pv_d       = pv_q;
        pchar_d    = pchar_q;
        pkey_d     = pkey_q;
        pidx_d     = pidx_q;
        sub_d      = 1'b0;
        commit_req = 1'b0;
        nxt        = 0;
        tap_d      = (tap_q < TW'(TAP_TIMEOUT)) ? tap_q + 1'b1 : tap_q;
        if (key_event) begin
            tap_d = '0;
            unique case (role)
                KEY_LETTER: begin
                    if (pv_q && key_index == pkey_q && tap_q < TW'(TAP_TIMEOUT)) begin
                        nxt = int'(pidx_q) + 1;
                        if (nxt >= letter_count(int'(key_index), LETTERS_PER_KEY)) nxt = 0;
                    end else begin
                        commit_req = pv_q && key_index != pkey_q;
                    end
                    pv_d    = 1'b1;
                    pkey_d  = key_index;
                    pidx_d  = KEY_W'(nxt);
                    pchar_d = letter_ascii(int'(key_index), nxt, LETTERS_PER_KEY);
                end
                KEY_COMMIT, KEY_CLEAR, KEY_SUBMIT_WORD: begin
                    commit_req = pv_q && role != KEY_CLEAR;
                    sub_d      = role == KEY_SUBMIT_WORD;
                    pv_d       = 1'b0;
                    pchar_d    = '0;
                    pidx_d     = '0;
                end
                default: ;
            endcase
        end
    end

    // Output slot frees on a handshake in the same cycle a new commit arrives.
    always_comb begin
        lv_d     = lv_q && !letter_ready;
        letter_d = letter_q;
        ovf_d    = 1'b0;
        ws_d     = sub_q;
        if (commit_req) begin
            if (!lv_q || letter_ready) begin
                lv_d     = 1'b1;
                letter_d = pchar_q;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q     <= 1'b0;
            pchar_q  <= '0;
            pkey_q   <= '0;
            pidx_q   <= '0;
            tap_q    <= '0;
            lv_q     <= 1'b0;
            letter_q <= '0;
            sub_q    <= 1'b0;
            ws_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            pv_q     <= pv_d;
            pchar_q  <= pchar_d;
            pkey_q   <= pkey_d;
            pidx_q   <= pidx_d;
            tap_q    <= tap_d;
            lv_q     <= lv_d;
            letter_q <= letter_d;
            sub_q    <= sub_d;
            ws_q     <= ws_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: tb/tb_keypad_multitap.sv
// Self-checking bench: a behavioural keypad drives rows from the column
// strobes; a press-level multi-tap model predicts pending and committed letters.
module tb_keypad_multitap;
    localparam int ROWS = 4;
    localparam int COLS = 3;
    localparam int LPK  = 3;
    localparam int NLET = (ROWS - 1) * COLS;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic            pending_valid, letter_valid, word_submit, overflow;
    logic            letter_ready = 1'b1;
    logic [7:0]      pending_char, letter;

    logic [ROWS*COLS-1:0] pressed = '0;

    int n_checks = 0;
    int n_pass   = 0;

    keypad_multitap dut (
        .clk(clk), .rst(rst), .row(row), .col(col),
        .pending_valid(pending_valid), .pending_char(pending_char),
        .letter_valid(letter_valid), .letter_ready(letter_ready), .letter(letter),
        .word_submit(word_submit), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Physical keypad: a held key connects its row to its column strobe.
    always_comb begin
        row = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pressed[r*COLS+c] && col[c]) row[r] = 1'b1;
    end

    // Handshake / pulse monitor.
    logic [7:0] got_q[$];
    int   cyc = 0, ws_cnt = 0, ovf_cnt = 0, lv_cyc = 0, ws_cyc = 0;
    logic lv_prev = 1'b0;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        lv_prev <= letter_valid;
        if (letter_valid && !lv_prev) lv_cyc <= cyc;
        if (word_submit) begin
            ws_cnt <= ws_cnt + 1;
            ws_cyc <= cyc;
        end
        if (overflow) ovf_cnt <= ovf_cnt + 1;
        if (letter_valid && letter_ready) got_q.push_back(letter);
    end

    // Reference model, one step per physical press.
    bit         m_pv;
    int         m_pkey, m_idx, m_submits;
    logic [7:0] exp_q[$];

    function automatic int nlet(input int k);
        int left;
        left = 26 - k * LPK;
        return (left < LPK) ? left : LPK;
    endfunction

    function automatic logic [7:0] mchar(input int k, input int i);
        return 8'(65 + k * LPK + i);
    endfunction

    task automatic model_press(input int k, input bit quick);
        if (k < NLET) begin
            if (m_pv && m_pkey == k && quick) m_idx = (m_idx + 1) % nlet(k);
            else begin
                if (m_pv && m_pkey != k) exp_q.push_back(mchar(m_pkey, m_idx));
                m_idx = 0;
            end
            m_pv   = 1'b1;
            m_pkey = k;
        end else begin
            if (m_pv && k != NLET + 1) exp_q.push_back(mchar(m_pkey, m_idx));
            if (k == NLET + 2) m_submits++;
            m_pv = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_mask(input logic [ROWS*COLS-1:0] m);
        pressed = m;
        idle(45);
        pressed = '0;
        idle(30);
    endtask

    task automatic press(input int k);
        logic [ROWS*COLS-1:0] m;
        m    = '0;
        m[k] = 1'b1;
        press_mask(m);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        pressed = '0;
        idle(3);
        rst       = 1'b0;
        m_pv      = 1'b0;
        m_pkey    = -1;
        m_idx     = 0;
        m_submits = 0;
        exp_q.delete();
        idle(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        n_checks++; if (col !== 3'b001) $display("FAIL reset_col got %b exp 001", col); else n_pass++;
        n_checks++;
        if ({pending_valid, pending_char, letter_valid, letter, word_submit, overflow} !== 19'd0)
            $display("FAIL reset_outputs got pv=%b pc=%h lv=%b l=%h ws=%b ov=%b exp all 0",
                     pending_valid, pending_char, letter_valid, letter, word_submit, overflow);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_single_press();
        int g0;
        do_reset();
        g0 = got_q.size();
        press(0);
        n_checks++; if (pending_valid !== 1'b1) $display("FAIL single_pv got %b exp 1", pending_valid); else n_pass++;
        n_checks++; if (pending_char !== 8'h41) $display("FAIL single_char got %h exp 41", pending_char); else n_pass++;
        n_checks++; if (got_q.size() !== g0) $display("FAIL single_nocommit got %0d exp %0d", got_q.size(), g0); else n_pass++;
    endtask

    task automatic test_multitap();
        logic [7:0] exp_c [3];
        int g0;
        exp_c[0] = 8'h4A; exp_c[1] = 8'h4B; exp_c[2] = 8'h4C;
        do_reset();
        letter_ready = 1'b0;
        g0 = got_q.size();
        for (int i = 0; i < 3; i++) begin
            press(3);
            n_checks++;
            if (pending_char !== exp_c[i]) $display("FAIL multitap_%0d got %h exp %h", i, pending_char, exp_c[i]);
            else n_pass++;
        end
        press(NLET);
        n_checks++; if (letter_valid !== 1'b1) $display("FAIL commit_lv got %b exp 1", letter_valid); else n_pass++;
        n_checks++; if (letter !== 8'h4C) $display("FAIL commit_letter got %h exp 4c", letter); else n_pass++;
        n_checks++; if (pending_valid !== 1'b0) $display("FAIL commit_pv got %b exp 0", pending_valid); else n_pass++;
        idle(20);
        n_checks++; if (letter_valid !== 1'b1) $display("FAIL commit_hold got %b exp 1", letter_valid); else n_pass++;
        letter_ready = 1'b1;
        idle(1);
        n_checks++; if (letter_valid !== 1'b0) $display("FAIL commit_drain got %b exp 0", letter_valid); else n_pass++;
        n_checks++;
        if (got_q.size() !== g0 + 1 || got_q[got_q.size()-1] !== 8'h4C)
            $display("FAIL commit_handshake got n=%0d exp n=%0d letter 4c", got_q.size() - g0, 1);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_c [3];
        exp_c[0] = 8'h59; exp_c[1] = 8'h5A; exp_c[2] = 8'h59;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            press(8);
            n_checks++;
            if (pending_char !== exp_c[i]) $display("FAIL wrap_%0d got %h exp %h", i, pending_char, exp_c[i]);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int g0;
        do_reset();
        g0 = got_q.size();
        press(0);
        idle(150);
        press(0);
        n_checks++; if (pending_char !== 8'h41) $display("FAIL timeout_char got %h exp 41", pending_char); else n_pass++;
        n_checks++; if (got_q.size() !== g0) $display("FAIL timeout_nocommit got %0d exp %0d", got_q.size(), g0); else n_pass++;
    endtask

    task automatic test_autocommit();
        int g0;
        do_reset();
        g0 = got_q.size();
        press(0);
        press(5);
        n_checks++; if (pending_char !== 8'h50) $display("FAIL auto_pending got %h exp 50", pending_char); else n_pass++;
        n_checks++; if (got_q.size() !== g0 + 1) $display("FAIL auto_count got %0d exp 1", got_q.size() - g0); else n_pass++;
        n_checks++;
        if (got_q.size() > g0 && got_q[g0] !== 8'h41) $display("FAIL auto_letter got %h exp 41", got_q[g0]);
        else n_pass++;
    endtask

    task automatic test_overflow();
        int o0;
        do_reset();
        letter_ready = 1'b0;
        o0 = ovf_cnt;
        press(0);
        press(NLET);
        press(1);
        press(NLET);
        n_checks++; if (ovf_cnt - o0 !== 1) $display("FAIL ovf_pulses got %0d exp 1", ovf_cnt - o0); else n_pass++;
        n_checks++; if (letter !== 8'h41) $display("FAIL ovf_letter got %h exp 41", letter); else n_pass++;
        n_checks++; if (letter_valid !== 1'b1) $display("FAIL ovf_lv got %b exp 1", letter_valid); else n_pass++;
        n_checks++; if (pending_valid !== 1'b0) $display("FAIL ovf_pv got %b exp 0", pending_valid); else n_pass++;
        letter_ready = 1'b1;
        idle(2);
    endtask

    task automatic test_submit();
        int g0, w0;
        do_reset();
        press(1);
        press(1);
        n_checks++; if (pending_char !== 8'h45) $display("FAIL submit_pending got %h exp 45", pending_char); else n_pass++;
        g0 = got_q.size();
        w0 = ws_cnt;
        press(NLET + 2);
        n_checks++;
        if (got_q.size() !== g0 + 1 || got_q[got_q.size()-1] !== 8'h45)
            $display("FAIL submit_letter got n=%0d exp n=1 letter 45", got_q.size() - g0);
        else n_pass++;
        n_checks++; if (ws_cnt - w0 !== 1) $display("FAIL submit_pulse got %0d cycles exp 1", ws_cnt - w0); else n_pass++;
        n_checks++; if (ws_cyc - lv_cyc !== 1) $display("FAIL submit_order got %0d exp 1", ws_cyc - lv_cyc); else n_pass++;
    endtask

    task automatic test_multirow();
        logic [ROWS*COLS-1:0] m;
        do_reset();
        m    = '0;
        m[1] = 1'b1;
        m[4] = 1'b1;
        press_mask(m);
        n_checks++; if (pending_char !== 8'h44) $display("FAIL multirow got %h exp 44", pending_char); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int g0;
        do_reset();
        press(0);
        g0 = got_q.size();
        pressed[2] = 1'b1;
        idle(20);
        rst = 1'b1;
        idle(1);
        n_checks++;
        if ({pending_valid, pending_char, letter_valid, letter, word_submit, overflow} !== 19'd0)
            $display("FAIL midrst_outputs got pv=%b pc=%h lv=%b l=%h exp all 0", pending_valid, pending_char, letter_valid, letter);
        else n_pass++;
        n_checks++; if (col !== 3'b001) $display("FAIL midrst_col got %b exp 001", col); else n_pass++;
        rst = 1'b0;
        idle(50);
        pressed = '0;
        idle(30);
        n_checks++; if (pending_char !== 8'h47) $display("FAIL midrst_fresh got %h exp 47", pending_char); else n_pass++;
        n_checks++; if (got_q.size() !== g0) $display("FAIL midrst_discard got %0d exp 0", got_q.size() - g0); else n_pass++;
    endtask

    task automatic test_random();
        int g0, w0, k, prev;
        bit quick;
        do_reset();
        g0   = got_q.size();
        w0   = ws_cnt;
        prev = -1;
        for (int n = 0; n < 30; n++) begin
            k = int'($urandom_range(0, ROWS * COLS - 1));
            if (prev >= 0 && prev < NLET && $urandom_range(0, 1) == 1) k = prev;
            quick = ($urandom_range(0, 3) != 0);
            if (!quick) idle(150);
            press(k);
            model_press(k, quick);
            prev = k;
            n_checks++;
            if (pending_valid !== m_pv || (m_pv && pending_char !== mchar(m_pkey, m_idx)))
                $display("FAIL rand_pending_%0d key %0d got pv=%b pc=%h exp pv=%b pc=%h",
                         n, k, pending_valid, pending_char, m_pv, mchar(m_pkey, m_idx));
            else n_pass++;
        end
        n_checks++;
        if (got_q.size() - g0 !== exp_q.size()) $display("FAIL rand_count got %0d exp %0d", got_q.size() - g0, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[g0+i] !== exp_q[i]) $display("FAIL rand_letter_%0d got %h exp %h", i, got_q[g0+i], exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (ws_cnt - w0 !== m_submits) $display("FAIL rand_submits got %0d exp %0d", ws_cnt - w0, m_submits); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_multitap();
        test_wrap();
        test_timeout();
        test_autocommit();
        test_overflow();
        test_submit();
        test_multirow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/keypad_multitap.md
KEYPAD_MULTITAP -- requirements
Module: keypad_multitap

Interface
REQ-001 Parameters: ROWS, default 4, matrix rows; COLS, default 3, matrix columns.
REQ-002 Parameters: DEBOUNCE_CYCLES, default 20, stable cycles per press/release; SCAN_CYCLES, default 4, dwell per column; TAP_TIMEOUT, default 100, multi-tap window in cycles; LETTERS_PER_KEY, default 3.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 row  input  ROWS  keypad row sense; active-high; asynchronous to clk.
REQ-006 col  output  COLS  one-hot column drive.
REQ-007 pending_valid  output  1  a letter is under multi-tap selection.
REQ-008 pending_char  output  8  ASCII of pending letter.
REQ-009 letter_valid / letter_ready  output/input  1/1  committed-letter handshake.
REQ-010 letter  output  8  committed ASCII letter.
REQ-011 word_submit  output  1  one-cycle pulse.
REQ-012 overflow  output  1  one-cycle pulse on dropped commit.

Function
REQ-013 row is double-flop synchronised before any use; adds 2 cycles of latency.
REQ-014 Key index = r*COLS+c; letter keys are indices < (ROWS-1)*COLS; last row: col0 COMMIT, col1 CLEAR, col2 SUBMIT_WORD; other indices are ignored.
REQ-015 Letter key k maps to 'A'+k*LETTERS_PER_KEY+i, i in 0..LETTERS_PER_KEY-1; codes above 'Z' are excluded from the cycle.
REQ-016 FSM states: SCAN, DB_PRESS, HELD, DB_RELEASE.
REQ-017 SCAN: col rotates c0→c1→…→wrap every SCAN_CYCLES; a nonzero synchronised row at the end of the dwell → DB_PRESS with col frozen.
REQ-018 DB_PRESS: the same row value for DEBOUNCE_CYCLES consecutive cycles → one press event, then HELD; any change → SCAN.
REQ-019 Multiple row bits set: lowest-index row wins.
REQ-020 HELD: row==0 → DB_RELEASE. DB_RELEASE: DEBOUNCE_CYCLES consecutive zeros → SCAN; any nonzero → HELD. No auto-repeat.
REQ-021 Same letter key pressed again within TAP_TIMEOUT cycles of the previous press: pending index i advances, wrapping to 0.
REQ-022 A press after timeout, or of a different letter key, sets i=0. A different key first auto-commits the current pending letter.
REQ-023 COMMIT with pending_valid: the letter is committed and pending cleared. COMMIT without pending: no effect.
REQ-024 CLEAR: pending cleared, nothing committed. SUBMIT_WORD: pending committed first if present, then word_submit pulses 1 cycle later.
REQ-025 Commit behaviour: letter/letter_valid are registered 1 cycle after the press event and held until letter_ready is sampled high.
REQ-026 A commit while letter_valid=1 and letter_ready=0 is dropped and overflow pulses.
REQ-027 A commit in the same cycle as letter_ready=1 on an existing letter is accepted.
REQ-028 The timeout counter saturates at TAP_TIMEOUT; no wrap.

Reset
REQ-029 rst high at a clock edge: FSM→SCAN, col=1 (bit0), all counters 0.
REQ-030 rst high at a clock edge: pending_valid=0, pending_char=0, letter_valid=0, letter=0, word_submit=0, overflow=0.
REQ-031 Reset mid-press discards any partial debounce and any pending letter.

Structure
REQ-032 Package keypad_pkg holds the FSM state enum, key-role enum (LETTER/COMMIT/CLEAR/SUBMIT_WORD/NONE), and the index→role/ASCII function.
REQ-033 Debounce/scan logic is a single sub-module keypad_scanner emitting key_event plus key_index; the multi-tap logic sits in the top.

Verification
REQ-034 Hold row=4'b0001 while col=001 for 25 cycles, release → one press (index 0); pending_char='A'.
REQ-035 Press key 3 three times, 30 cycles apart, then COMMIT → pending 'J','K','L'; letter='L'; letter_valid held until ready.
REQ-036 Press key 0, wait 150 cycles, press key 0 → pending_char='A', no advance.
REQ-037 Pending 'A', press key 5 → letter='A' committed; pending_char='P'.
REQ-038 letter_ready=0, two commits → second dropped, overflow pulse, letter unchanged.
REQ-039 Pending 'E', SUBMIT_WORD → letter='E', word_submit 1-cycle pulse; rst asserted mid-DB_PRESS → all outputs 0 the next cycle.
